mul_cell_combine: RTL and testbench

- Sequencing and combine stage directly downstream of the CPU multiply cell, which produces three registered 16x16 unsigned partial products p1, p2 and p3.
- Accepts a multiply request and drives the cell's clock enable for the cell's register latency.
- Captures the partials and reduces them in two registered add stages to the low 32 bits of the 32x32 product.
- Returns the result with a tag over a valid/ready handshake.

---
 rtl/mul_cell_combine.sv | 106 ++++++++++
 tb/tb_mul_cell_combine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_cell_combine.sv
// Sequencing and combine stage behind the 16x16 multiply cell.
// It gates the cell, reduces three partials to the low 32-bit product and returns it over valid/ready.
module mul_cell_combine #(
    parameter int CELL_LAT = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_ready,
    input  logic             flush,
    output logic             mul_en,
    input  logic [31:0]      cell_p1,
    input  logic [31:0]      cell_p2,
    input  logic [31:0]      cell_p3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(CELL_LAT - 1);

    state_t             state_reg;
    logic [1:0]         cnt_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [31:0]        a_lo_reg;
    logic [15:0]        a_mid_reg;
    logic [31:0]        out_result_reg;
    logic [TAG_W-1:0]   out_tag_reg;
    logic               out_valid_reg;
    logic               accept;
    logic               unused_hi;

    // Only the low halves of p2/p3 can reach the low 32 bits of the product.
    assign unused_hi = ^{cell_p2[31:16], cell_p3[31:16]};

    assign in_ready = (state_reg == IDLE) & ~flush;
    assign accept   = in_valid & in_ready;
    // The cell must stay frozen outside its fill window so the partials hold.
    assign mul_en   = accept | ((state_reg == WAIT) & (cnt_reg != 2'd0) & ~flush);
    assign busy     = (state_reg != IDLE);

    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_tag    = out_tag_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 2'd0;
            tag_reg        <= '0;
            a_lo_reg       <= 32'd0;
            a_mid_reg      <= 16'd0;
            out_result_reg <= 32'd0;
            out_tag_reg    <= '0;
            out_valid_reg  <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            cnt_reg       <= 2'd0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        tag_reg   <= in_tag;
                        cnt_reg   <= CNT_INIT;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg != 2'd0) begin
                        cnt_reg <= cnt_reg - 2'd1;
                    end else begin
                        a_lo_reg  <= cell_p1;
                        a_mid_reg <= cell_p2[15:0] + cell_p3[15:0];
                        state_reg <= SUM;
                    end
                end
                SUM: begin
                    out_result_reg <= a_lo_reg + {a_mid_reg, 16'h0000};
                    out_tag_reg    <= tag_reg;
                    out_valid_reg  <= 1'b1;
                    state_reg      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_cell_combine.sv
// Directed bench for mul_cell_combine: three instances (CELL_LAT 1..3), each driving a
// behavioural multiply cell built from enabled register stages.
module tb_mul_cell_combine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [2:0]       in_valid, in_ready, flush, mul_en, out_valid, out_ready, busy;
    logic [2:0][4:0]  in_tag, out_tag;
    logic [2:0][31:0] src1, src2, p1, p2, p3, out_result;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_inst
            logic [31:0] q1 [4];
            logic [31:0] q2 [4];

            mul_cell_combine #(.CELL_LAT(gi + 1), .TAG_W(5)) dut (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (in_valid[gi]),
                .in_tag    (in_tag[gi]),
                .in_ready  (in_ready[gi]),
                .flush     (flush[gi]),
                .mul_en    (mul_en[gi]),
                .cell_p1   (p1[gi]),
                .cell_p2   (p2[gi]),
                .cell_p3   (p3[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .out_result(out_result[gi]),
                .out_tag   (out_tag[gi]),
                .busy      (busy[gi])
            );

            // Cell model: CELL_LAT operand register stages gated by mul_en.
            always @(posedge clk) begin
                if (mul_en[gi]) begin
                    q1[0] <= src1[gi];
                    q2[0] <= src2[gi];
                    for (int j = 1; j < 4; j++) begin
                        q1[j] <= q1[j-1];
                        q2[j] <= q2[j-1];
                    end
                end
            end

            assign p1[gi] = 32'(q1[gi][15:0]) * 32'(q2[gi][15:0]);
            assign p2[gi] = 32'(q1[gi][15:0]) * 32'(q2[gi][31:16]);
            assign p3[gi] = 32'(q1[gi][31:16]) * 32'(q2[gi][15:0]);
        end
    endgenerate

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Starts at a negedge with instance k idle; returns in the cycle after the handshake.
    task automatic run_op(input int k, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [4:0] tag, input logic [31:0] exp, input int hold);
        int lat;
        lat = k + 1;
        src1[k] = s1;
        src2[k] = s2;
        in_tag[k] = tag;
        in_valid[k] = 1'b1;
        #1;
        chk("in_ready_accept", 32'(in_ready[k]), 32'd1);
        chk("mul_en_accept", 32'(mul_en[k]), 32'd1);
        @(negedge clk);
        in_valid[k] = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            #1;
            chk("out_valid_early", 32'(out_valid[k]), 32'd0);
            chk("mul_en_fill", 32'(mul_en[k]), (c < lat) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        in_valid[k] = (hold > 0);
        for (int h = 0; h <= hold; h++) begin
            out_ready[k] = (h == hold);
            #1;
            chk("out_valid", 32'(out_valid[k]), 32'd1);
            chk("out_result", out_result[k], exp);
            chk("out_tag", 32'(out_tag[k]), 32'(tag));
            if (hold > 0) begin
                chk("in_ready_done", 32'(in_ready[k]), 32'd0);
                chk("mul_en_done", 32'(mul_en[k]), 32'd0);
            end
            @(negedge clk);
        end
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b0;
        #1;
        chk("out_valid_after_hs", 32'(out_valid[k]), 32'd0);
        chk("busy_after_hs", 32'(busy[k]), 32'd0);
        $display("op inst_lat=%0d src1=%08h src2=%08h tag=%0d result=%08h expect=%08h",
                 lat, s1, s2, tag, out_result[k], exp);
    endtask

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{32'h0001_0003, 32'h0002_0005, 5'd7,  32'h000B_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[2] = '{32'h1234_5678, 32'h0000_0010, 5'd2,  32'h2345_6780};
        vecs[3] = '{32'h0000_0000, 32'h0000_1234, 5'd3,  32'h0000_0000};
        vecs[4] = '{32'h0000_FFFF, 32'h0000_FFFF, 5'd4,  32'hFFFE_0001};
        vecs[5] = '{32'h0001_0000, 32'h0001_0000, 5'd5,  32'h0000_0000};
        vecs[6] = '{32'h8000_0000, 32'h0000_0003, 5'd6,  32'h8000_0000};
        vecs[7] = '{32'h0003_0002, 32'h0004_0005, 5'd8,  32'h0017_000A};
        vecs[8] = '{32'hDEAD_BEEF, 32'h0000_0001, 5'd9,  32'hDEAD_BEEF};
        vecs[9] = '{32'h0001_0001, 32'h0001_0001, 5'd10, 32'h0002_0001};

        reset = 1'b1;
        in_valid = '0;
        flush = '0;
        out_ready = '0;
        in_tag = '0;
        src1 = '0;
        src2 = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_mul_en", 32'(mul_en[k]), 32'd0);
            chk("rst_out_result", out_result[k], 32'd0);
            chk("rst_out_tag", 32'(out_tag[k]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Vector table on CELL_LAT=1; vector 2 holds out_ready low for 5 cycles and is
        // immediately followed by a request in the cycle after the handshake.
        for (int i = 0; i < 10; i++) begin
            run_op(0, vecs[i].s1, vecs[i].s2, vecs[i].tag, vecs[i].exp, (i == 2) ? 5 : 0);
        end
        @(negedge clk);

        // CELL_LAT=2 and CELL_LAT=3 latency and mul_en window
        run_op(1, 32'h1234_5678, 32'h0000_0010, 5'd12, 32'h2345_6780, 0);
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001, 0);
        run_op(2, 32'h0001_0003, 32'h0002_0005, 5'd14, 32'h000B_000F, 0);
        @(negedge clk);

        // Flush in WAIT with cnt=1 on CELL_LAT=3
        src1[2] = 32'h0000_0002;
        src2[2] = 32'h0000_0003;
        in_tag[2] = 5'd9;
        in_valid[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        @(negedge clk);
        flush[2] = 1'b1;
        #1;
        chk("flush_mul_en", 32'(mul_en[2]), 32'd0);
        chk("flush_in_ready", 32'(in_ready[2]), 32'd0);
        @(negedge clk);
        flush[2] = 1'b0;
        #1;
        chk("post_flush_busy", 32'(busy[2]), 32'd0);
        chk("post_flush_mul_en", 32'(mul_en[2]), 32'd0);
        chk("post_flush_in_ready", 32'(in_ready[2]), 32'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            chk("flushed_no_valid", 32'(out_valid[2]), 32'd0);
        end
        @(negedge clk);
        run_op(2, 32'h0003_0002, 32'h0004_0005, 5'd11, 32'h0017_000A, 0);
        @(negedge clk);

        // Flush coincident with in_valid in IDLE is not accepted
        flush[0] = 1'b1;
        in_valid[0] = 1'b1;
        #1;
        chk("flush_idle_in_ready", 32'(in_ready[0]), 32'd0);
        chk("flush_idle_mul_en", 32'(mul_en[0]), 32'd0);
        @(negedge clk);
        flush[0] = 1'b0;
        in_valid[0] = 1'b0;
        #1;
        chk("flush_idle_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);

        // Reset asserted while in SUM on CELL_LAT=1
        src1[0] = 32'h0000_0007;
        src2[0] = 32'h0000_0006;
        in_tag[0] = 5'd21;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("sum_busy_before_reset", 32'(busy[0]), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_sum_out_valid", 32'(out_valid[0]), 32'd0);
        chk("reset_sum_busy", 32'(busy[0]), 32'd0);
        chk("reset_sum_in_ready", 32'(in_ready[0]), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            chk("reset_no_valid", 32'(out_valid[0]), 32'd0);
        end
        @(negedge clk);
        run_op(0, 32'h0000_0007, 32'h0000_0006, 5'd22, 32'h0000_002A, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
